// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM arbiter: FSM state encoding and requester IDs.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rom_arb_pick.sv
// Two-way tie resolution: a sole eligible requester wins, a tie goes to the
// requester that was not granted last.
module rom_arb_pick
  import rom_arb_pkg::*;
(
  input  logic a_elig,
  input  logic b_elig,
  input  logic last_grant,
  output logic grant
);

  always_comb begin
    grant = REQ_A;
    if (a_elig && b_elig) begin
      grant = (last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (b_elig) begin
      grant = REQ_B;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a synchronous ROM; IDLE-ISSUE-LATCH, ack 3 cycles after grant.
// Define ROM_ARB_FIXED_PRIO_EN for fixed A-over-B priority (no last-grant register).
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy
);

  state_t                  state, state_nxt;
  logic                    grant, grant_nxt;
  logic                    pick;
  logic                    last_grant;
  logic                    a_elig, b_elig;
  logic [ADDR_WIDTH-1:0]   rom_addr_nxt;
  logic                    rom_rd_nxt;
  logic                    a_ack_nxt, b_ack_nxt;
  logic [DATA_WIDTH-1:0]   a_data_nxt, b_data_nxt;

  // A requester acking this cycle is not eligible, so a held request is not re-read.
  assign a_elig = a_req && !a_ack;

`ifdef ROM_ARB_FIXED_PRIO_EN
  // B stays out while A is requesting, so A keeps the port even across its own ack cycle.
  assign b_elig     = b_req && !b_ack && !a_req;
  assign last_grant = REQ_B;
`else
  logic last_grant_nxt;

  assign b_elig = b_req && !b_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= REQ_B;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    last_grant_nxt = last_grant;
    if (state == IDLE && (a_elig || b_elig)) begin
      last_grant_nxt = pick;
    end
  end
`endif

  rom_arb_pick u_pick (
    .a_elig     (a_elig),
    .b_elig     (b_elig),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rom_addr_nxt = rom_addr;
    rom_rd_nxt   = 1'b0;
    a_ack_nxt    = 1'b0;
    b_ack_nxt    = 1'b0;
    a_data_nxt   = a_data;
    b_data_nxt   = b_data;
    case (state)
      IDLE: begin
        if (a_elig || b_elig) begin
          grant_nxt    = pick;
          rom_addr_nxt = (pick == REQ_A) ? a_addr : b_addr;
          rom_rd_nxt   = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = LATCH;
      end
      LATCH: begin
        if (grant == REQ_A) begin
          a_data_nxt = rom_data;
          a_ack_nxt  = 1'b1;
        end else begin
          b_data_nxt = rom_data;
          b_ack_nxt  = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= REQ_A;
      rom_addr <= '0;
      rom_rd   <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_data   <= '0;
      b_data   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rom_addr <= rom_addr_nxt;
      rom_rd   <= rom_rd_nxt;
      a_ack    <= a_ack_nxt;
      b_ack    <= b_ack_nxt;
      a_data   <= a_data_nxt;
      b_data   <= b_data_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: directed scenarios push expected acks, a negedge monitor checks them.
module tb_rom_arbiter;

  typedef struct {
    logic       port;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [7:0] a_addr = '0, b_addr = '0;
  logic       a_ack, b_ack, rom_rd, busy;
  logic [7:0] a_data, b_data, rom_addr;
  logic [7:0] rom_data = '0;
  logic [7:0] rom_mem [256];

  exp_t q[$];
  int   cyc = 0;
  int   last_ack = -100;
  int   n_checks = 0;
  int   n_pass = 0;

  rom_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_data(a_data),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_data(b_data),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rom_rd) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic port, input logic [7:0] data, input int c);
    exp_t e;
    e.port = port; e.data = data; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0;
    reset = 1'b1;
    step(2);
    chk("rst_rom_rd", 32'(rom_rd), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_acks", 32'({a_ack, b_ack}), 0);
    chk("rst_data", 32'({a_data, b_data}), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    last_ack = -100;
    step(1);
  endtask

  // Monitor: every ack must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!reset && (a_ack || b_ack)) begin
      chk("single_ack", 32'(a_ack && b_ack), 0);
      chk("rd_in_ack", 32'(rom_rd), 0);
      chk("ack_gap_ge3", 32'(cyc - last_ack >= 3), 1);
      last_ack = cyc;
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'(b_ack), 32'(~b_ack));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_port", 32'(b_ack), 32'(e.port));
        chk("ack_data", 32'(b_ack ? b_data : a_data), 32'(e.data));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int t0;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'h00;
    rom_mem[8'h12] = 8'hA5;
    rom_mem[8'h01] = 8'h11;
    rom_mem[8'h02] = 8'h22;
    rom_mem[8'h05] = 8'h55;

    // Single A read
    do_reset();
    t0 = cyc;
    a_addr = 8'h12; a_req = 1'b1;
    push(1'b0, 8'hA5, t0 + 3);
    step(1);
    chk("t1_rom_rd", 32'(rom_rd), 1);
    chk("t1_rom_addr", 32'(rom_addr), 32'h12);
    chk("t1_busy", 32'(busy), 1);
    step(1);
    chk("t1_rd_once", 32'(rom_rd), 0);
    step(1);
    a_req = 1'b0;
    step(3);
    chk("t1_b_data_held", 32'(b_data), 0);
    chk("t1_rom_addr_hold", 32'(rom_addr), 32'h12);
    chk("t1_q_empty", 32'(q.size()), 0);

    // Simultaneous requests: round-robin alternation
    do_reset();
    t0 = cyc;
    a_addr = 8'h01; b_addr = 8'h02; a_req = 1'b1; b_req = 1'b1;
    push(1'b0, 8'h11, t0 + 3);
    push(1'b1, 8'h22, t0 + 6);
    push(1'b0, 8'h11, t0 + 9);
    push(1'b1, 8'h22, t0 + 12);
    step(9);
    a_req = 1'b0;
    step(3);
    b_req = 1'b0;
    step(4);
    chk("t2_a_data_held", 32'(a_data), 32'h11);
    chk("t2_q_empty", 32'(q.size()), 0);

    // Request held through its own ack
    do_reset();
    t0 = cyc;
    a_addr = 8'h05; a_req = 1'b1;
    push(1'b0, 8'h55, t0 + 3);
    push(1'b0, 8'h55, t0 + 7);
    push(1'b0, 8'h55, t0 + 11);
    step(10);
    a_req = 1'b0;
    step(6);
    chk("t3_q_empty", 32'(q.size()), 0);

    // Late B request while A is in flight
    do_reset();
    t0 = cyc;
    a_addr = 8'h12; a_req = 1'b1;
    push(1'b0, 8'hA5, t0 + 3);
    push(1'b1, 8'h22, t0 + 6);
    step(1);
    b_addr = 8'h02; b_req = 1'b1;
    step(1);
    chk("t4_addr_stable", 32'(rom_addr), 32'h12);
    step(1);
    a_req = 1'b0;
    step(3);
    b_req = 1'b0;
    step(4);
    chk("t4_q_empty", 32'(q.size()), 0);

    // Reset during LATCH aborts the read; held request restarts cleanly
    do_reset();
    t0 = cyc;
    a_addr = 8'h12; a_req = 1'b1;
    step(2);
    reset = 1'b1;
    #1;
    chk("t5_abort_outs", 32'({a_ack, b_ack, rom_rd, busy}), 0);
    chk("t5_abort_data", 32'({a_data, b_data, rom_addr}), 0);
    step(1);
    reset = 1'b0;
    last_ack = -100;
    push(1'b0, 8'hA5, t0 + 6);
    step(3);
    a_req = 1'b0;
    step(4);
    chk("t5_q_empty", 32'(q.size()), 0);

`ifdef ROM_ARB_FIXED_PRIO_EN
    // Fixed priority: A monopolises the port until it drops its request
    do_reset();
    t0 = cyc;
    a_addr = 8'h01; b_addr = 8'h02; a_req = 1'b1; b_req = 1'b1;
    push(1'b0, 8'h11, t0 + 3);
    push(1'b0, 8'h11, t0 + 7);
    push(1'b0, 8'h11, t0 + 11);
    push(1'b1, 8'h22, t0 + 14);
    step(11);
    a_req = 1'b0;
    step(3);
    b_req = 1'b0;
    step(4);
    chk("t6_q_empty", 32'(q.size()), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
